// File: rtl/mmu_tx_rq_arb.sv
// Packet-level round-robin arbiter: merges NUM_REQ AXI-stream RQ requesters onto one
// registered 256-bit output stage, holding the grant from first beat to tlast.
module mmu_tx_rq_arb #(
  parameter int NUM_REQ = 4,
  parameter int GW      = 2
) (
  input  logic                   clk_sys,
  input  logic                   rst,
  input  logic [NUM_REQ*256-1:0] s_axis_rq_tdata,
  input  logic [NUM_REQ*60-1:0]  s_axis_rq_tuser,
  input  logic [NUM_REQ*32-1:0]  s_axis_rq_tkeep,
  input  logic [NUM_REQ-1:0]     s_axis_rq_tlast,
  input  logic [NUM_REQ-1:0]     s_axis_rq_tvalid,
  output logic [NUM_REQ-1:0]     s_axis_rq_tready,
  output logic [255:0]           m_axis_rq_tdata,
  output logic [59:0]            m_axis_rq_tuser,
  output logic [31:0]            m_axis_rq_tkeep,
  output logic                   m_axis_rq_tlast,
  output logic                   m_axis_rq_tvalid,
  input  logic                   m_axis_rq_tready,
  input  logic [15:0]            reg_tmout_cfg,
  output logic [GW-1:0]          arb_gnt_id,
  output logic                   arb_busy,
  output logic [31:0]            arb_pkt_cnt,
  output logic                   arb_tmout_err
);

  // Handshake: a beat moves on a clk_sys edge where tvalid and tready are both 1.
  // Requester tready is combinational from state and output-stage room only; tvalid
  // influences it solely through the candidate search while IDLE.

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [GW-1:0]   r_ptr;
  logic [GW-1:0]   w_ptr_nxt;
  logic [GW-1:0]   r_gnt;
  logic [GW-1:0]   w_gnt_nxt;
  logic [31:0]     r_pkt_cnt;
  logic [15:0]     r_stall_cnt;
  logic [15:0]     w_stall_inc;
  logic            r_tmout_err;

  logic [255:0]    r_m_tdata;
  logic [59:0]     r_m_tuser;
  logic [31:0]     r_m_tkeep;
  logic            r_m_tlast;
  logic            r_m_tvalid;

  logic            w_cand_vld;
  logic [GW-1:0]   w_cand_idx;
  logic [GW-1:0]   w_sel;
  logic            w_sel_en;
  logic            w_stg_rdy;
  logic            w_accept;
  logic [255:0]    w_sel_data;
  logic [59:0]     w_sel_user;
  logic [31:0]     w_sel_keep;
  logic            w_sel_last;
  logic            w_sel_valid;

  function automatic logic [GW-1:0] f_wrap_inc(input logic [GW-1:0] v);
    return (int'(v) == NUM_REQ - 1) ? '0 : v + 1'b1;
  endfunction

  assign w_stg_rdy = ~r_m_tvalid | m_axis_rq_tready;

  // Candidate is the valid requester at the smallest rotational distance from r_ptr.
  always_comb begin
    int v_dist;
    int v_best;
    w_cand_vld = 1'b0;
    w_cand_idx = '0;
    v_best     = NUM_REQ;
    v_dist     = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      v_dist = i - int'(r_ptr);
      if (v_dist < 0) v_dist = v_dist + NUM_REQ;
      if (s_axis_rq_tvalid[i] && (v_dist < v_best)) begin
        v_best     = v_dist;
        w_cand_vld = 1'b1;
        w_cand_idx = GW'(i);
      end
    end
  end

  assign w_sel    = (r_state == BUSY) ? r_gnt : w_cand_idx;
  assign w_sel_en = (r_state == BUSY) | w_cand_vld;

  always_comb begin
    w_sel_data  = '0;
    w_sel_user  = '0;
    w_sel_keep  = '0;
    w_sel_last  = 1'b0;
    w_sel_valid = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_sel == GW'(i)) begin
        w_sel_data  = s_axis_rq_tdata[i*256 +: 256];
        w_sel_user  = s_axis_rq_tuser[i*60 +: 60];
        w_sel_keep  = s_axis_rq_tkeep[i*32 +: 32];
        w_sel_last  = s_axis_rq_tlast[i];
        w_sel_valid = s_axis_rq_tvalid[i];
      end
    end
  end

  always_comb begin
    s_axis_rq_tready = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      s_axis_rq_tready[i] = w_sel_en & w_stg_rdy & (w_sel == GW'(i));
    end
  end

  assign w_accept = w_sel_en & w_stg_rdy & w_sel_valid;

  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    w_gnt_nxt   = r_gnt;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_gnt_nxt = w_sel;
          if (w_sel_last) w_ptr_nxt = f_wrap_inc(w_sel);
          else            w_state_nxt = BUSY;
        end
      end
      BUSY: begin
        if (w_accept && w_sel_last) begin
          w_state_nxt = IDLE;
          w_ptr_nxt   = f_wrap_inc(r_gnt);
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_sys) begin
    if (rst) begin
      r_state   <= IDLE;
      r_ptr     <= '0;
      r_gnt     <= '0;
      r_pkt_cnt <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_ptr   <= w_ptr_nxt;
      r_gnt   <= w_gnt_nxt;
      if (w_accept && w_sel_last) r_pkt_cnt <= r_pkt_cnt + 32'd1;
    end
  end

  // Stall watchdog: counts idle BUSY cycles, grant is never revoked by it.
  assign w_stall_inc = (r_stall_cnt == 16'hFFFF) ? r_stall_cnt : r_stall_cnt + 16'd1;

  always_ff @(posedge clk_sys) begin
    if (rst) begin
      r_stall_cnt <= '0;
      r_tmout_err <= 1'b0;
    end else if ((r_state == BUSY) && (reg_tmout_cfg != 16'd0) && !w_accept) begin
      r_stall_cnt <= w_stall_inc;
      if (w_stall_inc >= reg_tmout_cfg) r_tmout_err <= 1'b1;
    end else begin
      r_stall_cnt <= '0;
    end
  end

  always_ff @(posedge clk_sys) begin
    if (rst) begin
      r_m_tdata  <= '0;
      r_m_tuser  <= '0;
      r_m_tkeep  <= '0;
      r_m_tlast  <= 1'b0;
      r_m_tvalid <= 1'b0;
    end else if (w_accept) begin
      r_m_tdata  <= w_sel_data;
      r_m_tuser  <= w_sel_user;
      r_m_tkeep  <= w_sel_keep;
      r_m_tlast  <= w_sel_last;
      r_m_tvalid <= 1'b1;
    end else if (m_axis_rq_tready) begin
      r_m_tvalid <= 1'b0;
    end
  end

  assign m_axis_rq_tdata  = r_m_tdata;
  assign m_axis_rq_tuser  = r_m_tuser;
  assign m_axis_rq_tkeep  = r_m_tkeep;
  assign m_axis_rq_tlast  = r_m_tlast;
  assign m_axis_rq_tvalid = r_m_tvalid;
  assign arb_gnt_id       = r_gnt;
  assign arb_busy         = (r_state == BUSY);
  assign arb_pkt_cnt      = r_pkt_cnt;
  assign arb_tmout_err    = r_tmout_err;

endmodule

// File: tb/tb_mmu_tx_rq_arb.sv
// Bench for mmu_tx_rq_arb: randomized requester drivers, a packet-level arbitration
// model, and an output scoreboard fed by the model's accept predictions.
module tb_mmu_tx_rq_arb;

  localparam int NUM_REQ = 4;
  localparam int GW      = 2;
  localparam int BW      = 256 + 60 + 32 + 1;

  logic                   clk_sys;
  logic                   rst;
  logic [NUM_REQ*256-1:0] s_tdata;
  logic [NUM_REQ*60-1:0]  s_tuser;
  logic [NUM_REQ*32-1:0]  s_tkeep;
  logic [NUM_REQ-1:0]     s_tlast;
  logic [NUM_REQ-1:0]     s_tvalid;
  logic [NUM_REQ-1:0]     s_tready;
  logic [255:0]           m_tdata;
  logic [59:0]            m_tuser;
  logic [31:0]            m_tkeep;
  logic                   m_tlast;
  logic                   m_tvalid;
  logic                   m_tready;
  logic [15:0]            tmout_cfg;
  logic [GW-1:0]          gnt_id;
  logic                   busy;
  logic [31:0]            pkt_cnt;
  logic                   tmout_err;

  logic [BW-1:0] exp_q[$];
  logic [7:0]    src_log[$];
  int            n_vec;
  int            n_err;

  // Driver configuration and per-requester progress
  int            pkts_left[NUM_REQ];
  int            beat_idx[NUM_REQ];
  int            plen[NUM_REQ];
  int            gap[NUM_REQ];
  int            stall_first[NUM_REQ];
  logic [31:0]   seq[NUM_REQ];
  int            fixed_len;
  int            gap_max;
  logic [NUM_REQ-1:0] dut_acc;

  // Reference model state
  logic          mdl_busy;
  int            mdl_lock;
  int            mdl_ptr;
  int            mdl_gnt;
  logic [31:0]   mdl_pkt;
  logic          mdl_ovalid;
  int            mdl_stall;
  logic          mdl_err;

  mmu_tx_rq_arb #(.NUM_REQ(NUM_REQ), .GW(GW)) dut (
    .clk_sys          (clk_sys),
    .rst              (rst),
    .s_axis_rq_tdata  (s_tdata),
    .s_axis_rq_tuser  (s_tuser),
    .s_axis_rq_tkeep  (s_tkeep),
    .s_axis_rq_tlast  (s_tlast),
    .s_axis_rq_tvalid (s_tvalid),
    .s_axis_rq_tready (s_tready),
    .m_axis_rq_tdata  (m_tdata),
    .m_axis_rq_tuser  (m_tuser),
    .m_axis_rq_tkeep  (m_tkeep),
    .m_axis_rq_tlast  (m_tlast),
    .m_axis_rq_tvalid (m_tvalid),
    .m_axis_rq_tready (m_tready),
    .reg_tmout_cfg    (tmout_cfg),
    .arb_gnt_id       (gnt_id),
    .arb_busy         (busy),
    .arb_pkt_cnt      (pkt_cnt),
    .arb_tmout_err    (tmout_err)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk_sys = 1'b0;
    forever #5 clk_sys = ~clk_sys;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk_sys);
      #1;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(2);
    rst = 1'b0;
  endtask

  task automatic check(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp_v);
    n_vec++;
    if (act !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp_v);
    end
  endtask

  task automatic check_src(input string name, input int pos, input int exp_src);
    if (src_log.size() > pos) begin
      check(name, src_log[pos], exp_src);
    end else begin
      n_vec++;
      n_err++;
      $display("FAIL %s: packet missing, expected source %0d", name, exp_src);
    end
  endtask

  // ---------------- driver ----------------
  task automatic load_beat(input int i);
    logic [255:0] d;
    if (beat_idx[i] == 0) plen[i] = (fixed_len > 0) ? fixed_len : int'($urandom_range(1, 4));
    for (int w = 0; w < 8; w++) d[w*32 +: 32] = $urandom;
    d[255:248] = 8'(i);
    d[247:216] = seq[i];
    seq[i] = seq[i] + 32'd1;
    s_tdata[i*256 +: 256] = d;
    s_tuser[i*60 +: 60]   = 60'({$urandom, $urandom});
    s_tkeep[i*32 +: 32]   = $urandom;
    s_tlast[i]            = (beat_idx[i] == plen[i] - 1);
    s_tvalid[i]           = 1'b1;
  endtask

  always @(posedge clk_sys) begin
    #2;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (rst) begin
        s_tvalid[i]  = 1'b0;
        pkts_left[i] = 0;
        beat_idx[i]  = 0;
        gap[i]       = 0;
      end else if (dut_acc[i]) begin
        if (s_tlast[i]) begin
          pkts_left[i] = pkts_left[i] - 1;
          beat_idx[i]  = 0;
        end else begin
          beat_idx[i] = beat_idx[i] + 1;
        end
        gap[i] = (beat_idx[i] == 1 && stall_first[i] > 0) ? stall_first[i]
                                                          : int'($urandom_range(0, gap_max));
        s_tvalid[i] = 1'b0;
        if (pkts_left[i] > 0 && gap[i] == 0) load_beat(i);
      end else if (!s_tvalid[i] && pkts_left[i] > 0) begin
        if (gap[i] > 0) gap[i] = gap[i] - 1;
        if (gap[i] == 0) load_beat(i);
      end
    end
  end

  // ---------------- reference model + input-side checks ----------------
  always @(negedge clk_sys) begin : chk
    int   sel;
    int   j;
    logic stg;
    logic acc;
    logic busy_before;
    logic [NUM_REQ-1:0] exp_rdy;
    logic [BW-1:0] beat;
    if (rst) begin
      mdl_busy   = 1'b0;
      mdl_lock   = 0;
      mdl_ptr    = 0;
      mdl_gnt    = 0;
      mdl_pkt    = '0;
      mdl_ovalid = 1'b0;
      mdl_stall  = 0;
      mdl_err    = 1'b0;
      exp_q.delete();
      dut_acc    = '0;
    end else begin
      check("m_tvalid", m_tvalid, mdl_ovalid);
      check("arb_busy", busy, mdl_busy);
      check("arb_gnt_id", gnt_id, mdl_gnt);
      check("arb_pkt_cnt", pkt_cnt, mdl_pkt);
      check("arb_tmout_err", tmout_err, mdl_err);
      stg = !mdl_ovalid || m_tready;
      sel = -1;
      if (mdl_busy) begin
        sel = mdl_lock;
      end else begin
        for (int k = 0; k < NUM_REQ; k++) begin
          j = (mdl_ptr + k) % NUM_REQ;
          if (sel < 0 && s_tvalid[j]) sel = j;
        end
      end
      exp_rdy = '0;
      if (stg && sel >= 0) exp_rdy[sel] = 1'b1;
      check("s_tready", s_tready, exp_rdy);
      dut_acc = s_tvalid & s_tready;

      acc = (sel >= 0) && stg && s_tvalid[sel];
      busy_before = mdl_busy;
      if (acc) begin
        beat = {s_tdata[sel*256 +: 256], s_tuser[sel*60 +: 60], s_tkeep[sel*32 +: 32], s_tlast[sel]};
        exp_q.push_back(beat);
        mdl_gnt = sel;
        if (s_tlast[sel]) begin
          mdl_pkt  = mdl_pkt + 32'd1;
          mdl_busy = 1'b0;
          mdl_ptr  = (sel + 1) % NUM_REQ;
        end else begin
          mdl_busy = 1'b1;
          mdl_lock = sel;
        end
      end
      if (busy_before && tmout_cfg != 16'd0 && !acc) begin
        if (mdl_stall < 65535) mdl_stall = mdl_stall + 1;
        if (mdl_stall >= int'(tmout_cfg)) mdl_err = 1'b1;
      end else begin
        mdl_stall = 0;
      end
      mdl_ovalid = acc || (mdl_ovalid && !m_tready);
    end
  end

  // ---------------- output monitor / scoreboard ----------------
  always @(negedge clk_sys) begin : mon
    logic [BW-1:0] got;
    logic [BW-1:0] exp_b;
    if (!rst && m_tvalid && m_tready) begin
      got = {m_tdata, m_tuser, m_tkeep, m_tlast};
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL out_beat: unexpected beat %0h", got);
      end else begin
        exp_b = exp_q.pop_front();
        check("out_beat", got, exp_b);
      end
      if (m_tlast) src_log.push_back(m_tdata[255:248]);
    end
  end

  task automatic wait_drain(input int budget);
    int  left;
    logic done;
    m_tready = 1'b1;
    left = budget;
    done = 1'b0;
    while (!done && left > 0) begin
      done = (s_tvalid == '0) && !m_tvalid && !busy;
      for (int i = 0; i < NUM_REQ; i++) if (pkts_left[i] != 0) done = 1'b0;
      if (!done) begin
        step(1);
        left--;
      end
    end
    if (!done) begin
      n_vec++;
      n_err++;
      $display("FAIL drain_timeout: traffic still pending after %0d cycles", budget);
    end
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int base;
    int cyc;
    logic all_done;
    n_vec = 0;
    n_err = 0;
    rst = 1'b1;
    m_tready = 1'b1;
    tmout_cfg = '0;
    fixed_len = 1;
    gap_max = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      pkts_left[i] = 0;
      stall_first[i] = 0;
      seq[i] = '0;
      beat_idx[i] = 0;
      gap[i] = 0;
      plen[i] = 1;
    end

    // Reset state
    do_reset();
    @(negedge clk_sys);
    check("rst_m_tvalid", m_tvalid, 0);
    check("rst_m_tdata", m_tdata, 0);
    check("rst_m_tuser", m_tuser, 0);
    check("rst_m_tkeep", m_tkeep, 0);
    check("rst_m_tlast", m_tlast, 0);
    check("rst_busy", busy, 0);
    check("rst_pkt_cnt", pkt_cnt, 0);
    check("rst_tmout_err", tmout_err, 0);

    // Single 3-beat packet from requester 1, then ptr must sit at 2
    fixed_len = 3;
    base = src_log.size();
    pkts_left[1] = 1;
    wait_drain(200);
    check("single_pkt_cnt", pkt_cnt, 1);
    check_src("single_src", base, 1);
    fixed_len = 1;
    base = src_log.size();
    pkts_left[0] = 1;
    pkts_left[2] = 1;
    wait_drain(200);
    check_src("ptr2_first", base, 2);
    check_src("ptr2_second", base + 1, 0);

    // All requesters continuously valid with 2-beat packets
    do_reset();
    fixed_len = 2;
    gap_max = 0;
    base = src_log.size();
    for (int i = 0; i < NUM_REQ; i++) pkts_left[i] = 2;
    wait_drain(400);
    for (int k = 0; k < 8; k++) check_src("rr_order", base + k, k % NUM_REQ);
    check("rr_pkt_cnt", pkt_cnt, 8);

    // Backpressure 1010 with 4-beat packets from requesters 0 and 2
    fixed_len = 4;
    pkts_left[0] = 2;
    pkts_left[2] = 2;
    for (int c = 0; c < 60; c++) begin
      m_tready = (c % 2 == 0);
      step(1);
    end
    wait_drain(400);
    check("bp_pkt_cnt", pkt_cnt, 12);

    // Wrap: ptr=3 with requesters 0 and 3 pending
    do_reset();
    fixed_len = 1;
    base = src_log.size();
    pkts_left[2] = 1;
    wait_drain(200);
    pkts_left[0] = 1;
    pkts_left[3] = 1;
    wait_drain(200);
    check_src("wrap_a", base, 2);
    check_src("wrap_b", base + 1, 3);
    check_src("wrap_c", base + 2, 0);

    // Stall timeout
    tmout_cfg = 16'd16;
    fixed_len = 2;
    stall_first[1] = 20;
    pkts_left[1] = 1;
    step(5);
    check("tmo_busy_mid", busy, 1);
    check("tmo_err_early", tmout_err, 0);
    wait_drain(200);
    check("tmo_err_set", tmout_err, 1);
    step(3);
    check("tmo_err_sticky", tmout_err, 1);
    stall_first[1] = 0;
    tmout_cfg = '0;
    do_reset();
    @(negedge clk_sys);
    check("tmo_err_cleared", tmout_err, 0);

    // Randomized traffic with random backpressure and a short timeout
    do_reset();
    tmout_cfg = 16'($urandom_range(4, 12));
    gap_max = 3;
    fixed_len = 0;
    for (int i = 0; i < NUM_REQ; i++) pkts_left[i] = int'($urandom_range(5, 15));
    cyc = 0;
    all_done = 1'b0;
    while (cyc < 1500 && !all_done) begin
      m_tready = ($urandom_range(0, 3) != 0);
      step(1);
      cyc++;
      all_done = 1'b1;
      for (int i = 0; i < NUM_REQ; i++) if (pkts_left[i] != 0) all_done = 1'b0;
    end
    wait_drain(3000);
    check("rand_q_empty", exp_q.size(), 0);

    // Reset in the middle of a packet
    tmout_cfg = '0;
    gap_max = 2;
    fixed_len = 4;
    m_tready = 1'b1;
    pkts_left[0] = 3;
    cyc = 0;
    while (cyc < 50 && !busy) begin
      step(1);
      cyc++;
    end
    check("mid_busy_seen", busy, 1);
    rst = 1'b1;
    step(1);
    @(negedge clk_sys);
    check("mid_rst_m_tvalid", m_tvalid, 0);
    check("mid_rst_s_tready", s_tready, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_pkt_cnt", pkt_cnt, 0);
    step(1);
    rst = 1'b0;
    fixed_len = 1;
    gap_max = 0;
    base = src_log.size();
    for (int i = 0; i < NUM_REQ; i++) pkts_left[i] = 1;
    wait_drain(200);
    for (int k = 0; k < NUM_REQ; k++) check_src("post_rst_order", base + k, k);
    check("final_q_empty", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mmu_tx_rq_arb.md
Name: mmu_tx_rq_arb

Overview:
Packet-level round-robin arbiter that shares the 256-bit read-command RQ channel toward the VE between NUM_REQ requesters, such as the BD engine and the packet-read engine.
- Grant is locked from the first beat until the tlast beat of a packet, so packets never interleave.
- Output passes through one registered AXI-stream stage.
- Provides DFX counters and a stall-timeout flag.
- Sits between the tx_bd command generators and the raxi_rq256 FIFO toward PCIe.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
GW, 2, grant index width, equal to clog2(NUM_REQ)

Ports:
clk_sys  in  1  system clock
rst  in  1  reset; synchronous, active-high
s_axis_rq_tdata  in  NUM_REQ*256  requester data; requester i uses bits [i*256+:256]
s_axis_rq_tuser  in  NUM_REQ*60  requester user; requester i uses bits [i*60+:60]
s_axis_rq_tkeep  in  NUM_REQ*32  requester byte keep
s_axis_rq_tlast  in  NUM_REQ  requester end of packet
s_axis_rq_tvalid  in  NUM_REQ  requester valid
s_axis_rq_tready  out  NUM_REQ  requester ready
m_axis_rq_tdata  out  256  merged output data
m_axis_rq_tuser  out  60  merged output user
m_axis_rq_tkeep  out  32  merged output keep
m_axis_rq_tlast  out  1  merged output end of packet
m_axis_rq_tvalid  out  1  merged output valid
m_axis_rq_tready  in  1  downstream ready
reg_tmout_cfg  in  16  stall timeout in cycles; 0 disables the timeout
arb_gnt_id  out  GW  currently or last granted requester
arb_busy  out  1  1 while the arbiter is in state BUSY
arb_pkt_cnt  out  32  count of packets forwarded (tlast accepted)
arb_tmout_err  out  1  sticky stall-timeout flag

Behaviour:
- Reset (rst=1 at a clk_sys edge):
  - All outputs go to 0, including m_axis_rq_tdata/tuser/tkeep.
  - state=IDLE, ptr=0, stall counter=0.
  - Reset mid-packet drops the partial packet; requesters must also be reset.
- Output stage ready: stg_rdy = !m_axis_rq_tvalid | m_axis_rq_tready.
- Accept: a beat is accepted from requester i when s_axis_rq_tvalid[i] & s_axis_rq_tready[i]. The accepted beat is registered into the m_axis stage with 1-cycle latency.
- When an accept and a downstream take happen in the same cycle, m_axis_rq_tvalid stays 1 and the new beat replaces the old one.
- When the stage is taken with no new accept, m_axis_rq_tvalid goes to 0.
- s_axis_rq_tready is combinational:
  - It is 0 for every non-granted requester.
  - For the granted requester it equals stg_rdy.
  - tready must not depend on tvalid except through the IDLE grant selection.
- State IDLE:
  - Candidate = first i with tvalid[i]=1, searching ptr, ptr+1, ... with wrap-around modulo NUM_REQ.
  - When a candidate exists, it is granted in the same cycle (arb_gnt_id updates on the next edge).
  - If the beat is accepted with tlast=1: stay IDLE, ptr = (i+1) mod NUM_REQ, arb_pkt_cnt += 1.
  - If the beat is accepted with tlast=0: go to BUSY and lock the grant to i.
  - If stg_rdy=0: no grant, stay IDLE, candidate re-evaluated next cycle.
- State BUSY:
  - Only the locked requester is served.
  - When the tlast beat is accepted: go to IDLE, ptr = (gnt+1) mod NUM_REQ, arb_pkt_cnt += 1.
  - tvalid gaps from the locked requester are allowed; the grant is held.
- Fairness: each requester waits at most NUM_REQ-1 packets before it is granted.
- Counter width rule: arb_pkt_cnt is 32-bit and wraps from 0xFFFF_FFFF to 0 with no flag.
- Stall timeout:
  - Active only in BUSY with reg_tmout_cfg != 0.
  - The stall counter increments each cycle with no accepted beat and clears on any accepted beat or on leaving BUSY.
  - When the counter reaches reg_tmout_cfg, arb_tmout_err is set to 1 and held until rst.
  - The grant is not released on timeout.
  - The counter saturates at 0xFFFF.
- Requester tvalid dropping while in IDLE is tolerated.
- Data on the output is exactly the accepted beat: no reordering, keep/user passed unchanged.

Test Plan:
- Single requester 1, 3-beat packet, m_tready=1 → m_tvalid high cycles 1-3 after first accept, data in order, tlast on the 3rd beat, arb_pkt_cnt=1, ptr=2.
- All 4 requesters continuously valid with 2-beat packets → output packet source order 0,1,2,3,0,... with no interleaving; arb_pkt_cnt=8 after 16 output beats.
- Backpressure: m_tready toggles 1010 during 4-beat packets from requesters 0 and 2 → no beat lost or duplicated, s_tready[2]=0 until requester 0 tlast is accepted.
- Wrap/fairness: ptr=3, requesters 0 and 3 valid → requester 3 granted first, then 0; NUM_REQ=2 build repeats the round-robin check.
- Timeout: reg_tmout_cfg=16, requester 1 sends 1 beat with tlast=0 then goes idle for 20 cycles → arb_tmout_err=1 on the 16th stalled cycle, arb_busy stays 1; the tlast beat then completes the packet and the flag stays 1 until rst.
- Reset asserted in BUSY mid-packet → next cycle m_tvalid=0, all s_tready=0, arb_busy=0, arb_pkt_cnt=0; after rst releases, requester 0 is granted first.
